// File: rtl/wb_cmd_master.sv
// Command-driven Wishbone B3 master: single and incrementing-burst reads and
// writes. Every beat is strobed, acknowledged, then followed by a one-cycle
// strobe gap, so a slave that registers its ack is handled correctly.
//
// Handshakes: a transfer on cmd_* or wr_* happens on a rising edge where
// both valid and ready are high; ready depends only on state, never on valid.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [3:0]  cmd_len_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [31:0] wr_data_i,
    output logic        rd_valid_o,
    output logic [31:0] rd_data_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [4:0]  beats_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    output logic [2:0]  cti_o,
    output logic [1:0]  bte_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_STROBE = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Value the timeout counter holds during the last permitted strobe cycle.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state;
    logic        r_cyc, w_cyc;
    logic        r_stb, w_stb;
    logic        r_we, w_we;
    logic [31:0] r_adr, w_adr;
    logic [31:0] r_dat, w_dat;
    logic [3:0]  r_sel, w_sel;
    logic [2:0]  r_cti, w_cti;
    logic [3:0]  r_len, w_len;
    logic [4:0]  r_beats, w_beats;
    logic [7:0]  r_tmo, w_tmo;
    logic        r_rd_valid, w_rd_valid;
    logic [31:0] r_rd_data, w_rd_data;
    logic        r_done, w_done;
    logic [1:0]  r_status, w_status;
    logic [4:0]  r_beats_out, w_beats_out;
    logic        w_last_beat;

    // Address bits [1:0] are dropped: the bus is word addressed.
    logic w_unused_adr_lsb;
    assign w_unused_adr_lsb = &{1'b0, cmd_adr_i[1:0]};

    // Cycle type for beat idx of a len+1 beat command.
    function automatic logic [2:0] f_cti(input logic [4:0] idx, input logic [3:0] len);
        if (len == 4'd0)
            return 3'b000;
        else if (idx == {1'b0, len})
            return 3'b111;
        else
            return 3'b010;
    endfunction

    assign cmd_ready_o = (r_state == S_IDLE);
    assign wr_ready_o  = (r_state == S_FETCH);
    assign w_last_beat = (r_beats == {1'b0, r_len});

    assign cyc_o       = r_cyc;
    assign stb_o       = r_stb;
    assign we_o        = r_we;
    assign adr_o       = r_adr;
    assign dat_o       = r_dat;
    assign sel_o       = r_sel;
    assign cti_o       = r_cti;
    assign bte_o       = 2'b00;
    assign rd_valid_o  = r_rd_valid;
    assign rd_data_o   = r_rd_data;
    assign done_o      = r_done;
    assign status_o    = r_status;
    assign beats_o     = r_beats_out;
    assign dbg_state_o = r_state;

    // Next-state and next-output decode; terminations only count while strobing.
    always_comb begin
        w_state     = r_state;
        w_cyc       = r_cyc;
        w_stb       = r_stb;
        w_we        = r_we;
        w_adr       = r_adr;
        w_dat       = r_dat;
        w_sel       = r_sel;
        w_cti       = r_cti;
        w_len       = r_len;
        w_beats     = r_beats;
        w_tmo       = r_tmo;
        w_rd_valid  = 1'b0;
        w_rd_data   = r_rd_data;
        w_done      = 1'b0;
        w_status    = r_status;
        w_beats_out = r_beats_out;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_adr   = {cmd_adr_i[31:2], 2'b00};
                    w_len   = cmd_len_i;
                    w_we    = cmd_we_i;
                    w_sel   = cmd_sel_i;
                    w_beats = 5'd0;
                    if (cmd_we_i) begin
                        w_state = S_FETCH;
                        w_cyc   = 1'b0;
                        w_stb   = 1'b0;
                    end else begin
                        w_state = S_STROBE;
                        w_cyc   = 1'b1;
                        w_stb   = 1'b1;
                        w_tmo   = 8'd0;
                        w_cti   = f_cti(5'd0, cmd_len_i);
                    end
                end
            end
            S_FETCH: begin
                if (wr_valid_i) begin
                    w_dat   = wr_data_i;
                    w_state = S_STROBE;
                    w_cyc   = 1'b1;
                    w_stb   = 1'b1;
                    w_tmo   = 8'd0;
                    w_cti   = f_cti(r_beats, r_len);
                end
            end
            S_STROBE: begin
                if (err_i || rty_i) begin
                    w_state     = S_DONE;
                    w_cyc       = 1'b0;
                    w_stb       = 1'b0;
                    w_done      = 1'b1;
                    w_status    = err_i ? 2'd1 : 2'd2;
                    w_beats_out = r_beats;
                end else if (ack_i) begin
                    w_beats = r_beats + 5'd1;
                    if (!r_we) begin
                        w_rd_data  = dat_i;
                        w_rd_valid = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state     = S_DONE;
                        w_cyc       = 1'b0;
                        w_stb       = 1'b0;
                        w_done      = 1'b1;
                        w_status    = 2'd0;
                        w_beats_out = r_beats + 5'd1;
                    end else begin
                        w_adr   = r_adr + 32'd4;
                        w_stb   = 1'b0;
                        w_state = r_we ? S_FETCH : S_GAP;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_state     = S_DONE;
                    w_cyc       = 1'b0;
                    w_stb       = 1'b0;
                    w_done      = 1'b1;
                    w_status    = 2'd3;
                    w_beats_out = r_beats;
                end else begin
                    w_tmo = r_tmo + 8'd1;
                end
            end
            S_GAP: begin
                w_state = S_STROBE;
                w_stb   = 1'b1;
                w_tmo   = 8'd0;
                w_cti   = f_cti(r_beats, r_len);
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_cyc   = 1'b0;
                w_stb   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus and any pending pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 32'd0;
            r_dat       <= 32'd0;
            r_sel       <= 4'd0;
            r_cti       <= 3'd0;
            r_len       <= 4'd0;
            r_beats     <= 5'd0;
            r_tmo       <= 8'd0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 32'd0;
            r_done      <= 1'b0;
            r_status    <= 2'd0;
            r_beats_out <= 5'd0;
        end else begin
            r_state     <= w_state;
            r_cyc       <= w_cyc;
            r_stb       <= w_stb;
            r_we        <= w_we;
            r_adr       <= w_adr;
            r_dat       <= w_dat;
            r_sel       <= w_sel;
            r_cti       <= w_cti;
            r_len       <= w_len;
            r_beats     <= w_beats;
            r_tmo       <= w_tmo;
            r_rd_valid  <= w_rd_valid;
            r_rd_data   <= w_rd_data;
            r_done      <= w_done;
            r_status    <= w_status;
            r_beats_out <= w_beats_out;
        end
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Command-driven Wishbone B3 master that issues single and incrementing-burst register reads and writes to the card's Wishbone register slave. It sits between the PCI-side command logic and the register bus, and drives the cyc/stb/adr/cti/bte/we/sel/dat signals the slave samples. Every beat is strobed, acknowledged and then followed by a one-cycle strobe gap. This keeps it correct against a slave whose ack is registered, one cycle after strobe. Completion is reported with a done pulse and a status code.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles stb_o may stay high without ack_i/err_i/rty_i before abort (8-bit counter).

Ports:
- clk_i  in  1  clock; everything sampled on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  high only in IDLE.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  starting byte address; bits [1:0] ignored, driven 0.
- cmd_len_i  in  4  beats minus one (0 = single, 15 = 16 beats).
- cmd_sel_i  in  4  byte select used for every beat.
- wr_valid_i / wr_ready_o  in/out  1  write-data handshake; a word transfers when both are high.
- wr_data_i  in  32  write data word.
- rd_valid_o  out  1  one-cycle pulse per read beat.
- rd_data_o  out  32  read data, valid with rd_valid_o.
- done_o  out  1  one-cycle pulse at command end.
- status_o  out  2  0 ok, 1 err_i, 2 rty_i, 3 timeout; held until the next done_o.
- beats_o  out  5  beats acknowledged in the last command; held like status_o.
- cyc_o, stb_o, we_o  out  1 each  Wishbone controls.
- adr_o  out  32  Wishbone address.
- dat_o  out  32  Wishbone write data.
- sel_o  out  4  Wishbone byte select.
- cti_o  out  3  Wishbone cycle type.
- bte_o  out  2  Wishbone burst type.
- dat_i  in  32  Wishbone read data.
- ack_i, err_i, rty_i  in  1 each  Wishbone terminations.

## Operation
- All outputs are registered except cmd_ready_o and wr_ready_o, which decode state.
- Reset values: all outputs 0, except status_o = 0 and beats_o = 0; state IDLE.
- States:
  - IDLE: cmd_ready_o=1. On accept, latch address, length, we and sel, and clear the beat counter. A write goes to FETCH; a read goes to STROBE.
  - FETCH: wr_ready_o=1, stb_o=0. cyc_o=1 only if at least one beat is already done. On a wr handshake, latch dat_o and go to STROBE. With no word, wait indefinitely.
  - STROBE: cyc_o=1, stb_o=1, timeout counter runs. Termination inputs are honoured only here, with priority err_i > rty_i > ack_i.
    - On ack_i: increment the beat counter. On a read, capture dat_i into rd_data_o and pulse rd_valid_o the next cycle. If it was the last beat, go to DONE. Otherwise adr_o += 4, then go to FETCH (write) or GAP (read).
    - On err_i / rty_i / timeout: go to DONE with status 1 / 2 / 3; the beat is not counted.
  - GAP: cyc_o=1, stb_o=0 for exactly one cycle, then STROBE.
  - DONE: cyc_o=0, stb_o=0, done_o=1, status_o and beats_o updated; next state IDLE.
- cti_o: 000 for a single-beat command. For a burst, 010 on every beat except the last, and 111 on the last. bte_o is always 00 (linear).
- ack_i, err_i and rty_i arriving while stb_o=0 are ignored. This discards the slave's duplicate registered ack.
- Timeout counter: cleared on entry to STROBE. It aborts when it reaches TIMEOUT_CYCLES without a termination.
- Reset mid-command: cyc_o and stb_o are 0 at the next edge. There is no done_o, and any pending rd_valid_o is dropped.

## Timing
- Read, accepted at edge E0:
  - cyc/stb/adr valid from cycle 1.
  - Slave ack sampled in cycle 2; rd_valid_o in cycle 3.
  - Non-last beat: stb low in cycle 3, next strobe in cycle 4. Sustained rate is one beat per 3 cycles.
  - Last beat: done_o and cyc_o=0 in cycle 3 (same cycle as the final rd_valid_o); cmd_ready_o=1 in cycle 4.
- Write, accepted at E0 with wr_valid_i already high:
  - FETCH in cycle 1, strobe in cycle 2, ack in cycle 3.
  - FETCH/gap in cycle 4 (or DONE if last beat).
  - Each extra cycle wr_valid_i stays low adds one cycle.
- A command is never accepted in the cycle done_o is high.

## Test plan
- Single read at 0x0000_0014, slave returns 0x0000_0ABC. Require:
  - cti_o=000, exactly one rd_valid_o with 0x0000_0ABC;
  - done_o in cycle 3, status_o=0, beats_o=1;
  - the duplicate ack in cycle 3 is ignored.
- 4-beat write at 0x0, data 0x11, 0x22, 0x33, 0x44, sel=0xF. Require:
  - adr_o 0x0, 0x4, 0x8, 0xC;
  - cti_o 010, 010, 010, 111;
  - beats_o=4, status_o=0.
- 16-beat read with cmd_len_i=15. Require:
  - 16 rd_valid_o pulses in order;
  - final adr_o 0x3C;
  - done_o at cycle 48 after accept.
- Write burst where wr_valid_i drops for 5 cycles before beat 2. Require:
  - cyc_o stays 1 and stb_o stays 0 during the stall;
  - no extra beats; beats_o=3 for cmd_len_i=2.
- err_i on beat 2 of a 4-beat read. Require status_o=1, beats_o=1, done_o on the next cycle, and cyc_o=0.
- No termination with TIMEOUT_CYCLES=8. Require status_o=3 and beats_o=0, then reset_i asserted mid-burst forces cyc_o=0 at the next edge with no done_o.
